// File: rtl/instruction_fetch_pkg.sv
// Shared widths, FSM encoding and PC arithmetic for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int unsigned BIT_INST   = 16;
    localparam int unsigned SZB_INS    = 4;
    localparam int unsigned IMEM_DEPTH = 2 ** SZB_INS;

    typedef logic [BIT_INST-1:0] inst_t;
    typedef logic [SZB_INS-1:0]  addr_t;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    typedef struct packed {
        logic  we;
        addr_t addr;
        inst_t data;
    } imem_wr_t;

    // Offset is already SZB_INS wide, so sign extension is the identity and the add wraps naturally.
    function automatic addr_t pc_step(input addr_t pc, input logic en_offset,
                                      input logic en_cnt, input addr_t offset);
        addr_t nxt;
        nxt = pc;
        if (en_offset) begin
            nxt = pc + offset;
        end else if (en_cnt) begin
            nxt = pc + addr_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Controller <-> fetch stage bus: PC decision and IMEM write in, instruction word out.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic  interrupt;
    inst_t io_cmd;
    inst_t io_data;
    logic  ins_we;
    addr_t addr_ins;
    logic  en_cnt;
    logic  en_offset;
    addr_t pc_offset;
    inst_t instructions;
    addr_t pc;
    logic  fetch_valid;

    modport master (
        output interrupt, io_cmd, io_data, ins_we, addr_ins, en_cnt, en_offset, pc_offset,
        input  instructions, pc, fetch_valid
    );

    modport slave (
        input  interrupt, io_cmd, io_data, ins_we, addr_ins, en_cnt, en_offset, pc_offset,
        output instructions, pc, fetch_valid
    );

endinterface

// File: rtl/instruction_fetch_ins_mem.sv
// Instruction memory: one synchronous write port, one combinational read port, contents survive reset.
module instruction_fetch_ins_mem
    import instruction_fetch_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  imem_wr_t i_wr,
    input  addr_t    i_raddr,
    output inst_t    o_rdata_c
);

    inst_t r_mem [IMEM_DEPTH];

    // Reset leaves the array alone but blocks any write attempted while it is asserted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
        end else if (i_wr.we) begin
            r_mem[i_wr.addr] <= i_wr.data;
        end
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC and 3-cycle FETCH/DECODE/UPDATE slot around the instruction memory.
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    instruction_fetch_if.slave bus
);

    state_t   r_state;
    state_t   w_state_nxt;
    inst_t    r_instructions;
    inst_t    w_instructions_nxt;
    addr_t    r_pc;
    addr_t    w_pc_nxt;
    logic     r_fetch_valid;
    logic     w_fetch_valid_nxt;
    inst_t    w_imem_rdata;
    imem_wr_t w_imem_wr;

    always_comb begin
        w_imem_wr.we   = bus.ins_we;
        w_imem_wr.addr = bus.addr_ins;
        w_imem_wr.data = bus.io_data;
    end

    instruction_fetch_ins_mem u_ins_mem (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr      (w_imem_wr),
        .i_raddr   (r_pc),
        .o_rdata_c (w_imem_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fixed rotation; the unused encoding falls back to FETCH.
    always_comb begin
        w_state_nxt = S_FETCH;
        case (r_state)
            S_FETCH:  w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = S_UPDATE;
            S_UPDATE: w_state_nxt = S_FETCH;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    // Read happens before any same-edge IMEM write, so FETCH sees the old word.
    always_comb begin
        w_instructions_nxt = r_instructions;
        w_pc_nxt           = r_pc;
        w_fetch_valid_nxt  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_instructions_nxt = bus.interrupt ? bus.io_cmd : w_imem_rdata;
                w_fetch_valid_nxt  = 1'b1;
            end
            S_UPDATE: begin
                w_pc_nxt = pc_step(r_pc, bus.en_offset, bus.en_cnt, bus.pc_offset);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instructions <= '0;
            r_pc           <= '0;
            r_fetch_valid  <= 1'b0;
        end else begin
            r_instructions <= w_instructions_nxt;
            r_pc           <= w_pc_nxt;
            r_fetch_valid  <= w_fetch_valid_nxt;
        end
    end

    assign bus.instructions = r_instructions;
    assign bus.pc           = r_pc;
    assign bus.fetch_valid  = r_fetch_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential run, jumps, wrap, interrupt, IMEM write, resets.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    instruction_fetch_if u_if ();

    instruction_fetch u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic inst_t init_word(input int i);
        case (i)
            0:       return 16'h1234;
            1:       return 16'h5678;
            2:       return 16'h9ABC;
            default: return 16'hA000 | inst_t'(i);
        endcase
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        u_if.interrupt = 1'b0;
        u_if.io_cmd    = '0;
        u_if.io_data   = '0;
        u_if.ins_we    = 1'b0;
        u_if.addr_ins  = '0;
        u_if.en_cnt    = 1'b0;
        u_if.en_offset = 1'b0;
        u_if.pc_offset = '0;

        repeat (2) tick();
        check("rst_pc", 32'(u_if.pc), 32'h0);
        check("rst_instr", 32'(u_if.instructions), 32'h0);
        check("rst_fv", 32'(u_if.fetch_valid), 32'h0);

        // Preload IMEM while parked in IO mode with the PC frozen at 0.
        rst_n = 1'b1;
        u_if.interrupt = 1'b1;
        u_if.io_cmd    = 16'h7777;
        for (int i = 0; i < 16; i++) begin
            u_if.ins_we   = 1'b1;
            u_if.addr_ins = addr_t'(i);
            u_if.io_data  = init_word(i);
            tick();
        end
        u_if.ins_we = 1'b0;
        check("load_io_instr", 32'(u_if.instructions), 32'h7777);

        rst_n = 1'b0;
        u_if.interrupt = 1'b0;
        #1;
        check("rst2_instr", 32'(u_if.instructions), 32'h0);
        check("rst2_fv", 32'(u_if.fetch_valid), 32'h0);
        tick();
        rst_n = 1'b1;
        u_if.en_cnt = 1'b1;

        // Sequential run
        tick();
        check("seq0_fv", 32'(u_if.fetch_valid), 32'h1);
        check("seq0_instr", 32'(u_if.instructions), 32'h1234);
        check("seq0_pc", 32'(u_if.pc), 32'h0);
        tick();
        check("seq0_dec_fv", 32'(u_if.fetch_valid), 32'h0);
        check("seq0_dec_instr", 32'(u_if.instructions), 32'h1234);
        tick();
        check("seq0_pc_upd", 32'(u_if.pc), 32'h1);
        tick();
        check("seq1_instr", 32'(u_if.instructions), 32'h5678);
        tick(); tick();
        check("seq1_pc_upd", 32'(u_if.pc), 32'h2);
        tick();
        check("seq2_instr", 32'(u_if.instructions), 32'h9ABC);
        tick(); tick();
        check("seq2_pc_upd", 32'(u_if.pc), 32'h3);

        // IMEM write to the address being fetched in the same cycle
        u_if.en_cnt   = 1'b0;
        u_if.ins_we   = 1'b1;
        u_if.addr_ins = 4'd3;
        u_if.io_data  = 16'hBEEF;
        tick();
        u_if.ins_we = 1'b0;
        check("wr_old_word", 32'(u_if.instructions), 32'hA003);
        u_if.en_offset = 1'b1;
        u_if.pc_offset = 4'd2;
        tick(); tick();
        check("stall_then_jump_pc", 32'(u_if.pc), 32'h5);
        u_if.en_offset = 1'b0;

        // Offset has priority over increment: 5 + (-3) = 2
        tick();
        check("jmp5_instr", 32'(u_if.instructions), 32'hA005);
        u_if.en_offset = 1'b1;
        u_if.en_cnt    = 1'b1;
        u_if.pc_offset = 4'hD;
        tick(); tick();
        check("jmp_prio_pc", 32'(u_if.pc), 32'h2);
        u_if.en_cnt = 1'b0;
        tick();
        check("jmp2_instr", 32'(u_if.instructions), 32'h9ABC);
        tick(); tick();
        check("jmp_neg_wrap_pc", 32'(u_if.pc), 32'hF);

        // Increment wraps 15 -> 0
        u_if.en_offset = 1'b0;
        u_if.en_cnt    = 1'b1;
        tick();
        check("pc15_instr", 32'(u_if.instructions), 32'hA00F);
        tick(); tick();
        check("inc_wrap_pc", 32'(u_if.pc), 32'h0);

        // Interrupt: IO command replaces IMEM data, PC held by the controller
        u_if.en_cnt    = 1'b0;
        u_if.interrupt = 1'b1;
        u_if.io_cmd    = 16'hF0A0;
        tick();
        check("irq0_instr", 32'(u_if.instructions), 32'hF0A0);
        tick(); tick();
        check("irq0_pc", 32'(u_if.pc), 32'h0);
        tick();
        check("irq1_instr", 32'(u_if.instructions), 32'hF0A0);
        u_if.interrupt = 1'b0;
        tick(); tick();
        check("irq_fall_hold", 32'(u_if.instructions), 32'hF0A0);
        u_if.en_cnt = 1'b1;
        tick();
        check("irq_resume_instr", 32'(u_if.instructions), 32'h1234);
        tick(); tick();
        check("irq_resume_pc", 32'(u_if.pc), 32'h1);

        // Async reset during UPDATE with en_cnt high
        tick();
        check("pre_rst_instr", 32'(u_if.instructions), 32'h5678);
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_pc", 32'(u_if.pc), 32'h0);
        check("arst_instr", 32'(u_if.instructions), 32'h0);
        check("arst_fv", 32'(u_if.fetch_valid), 32'h0);
        tick();
        check("arst_hold_pc", 32'(u_if.pc), 32'h0);
        rst_n = 1'b1;
        tick();
        check("arst_fetch_fv", 32'(u_if.fetch_valid), 32'h1);
        check("arst_fetch_instr", 32'(u_if.instructions), 32'h1234);
        check("arst_fetch_pc", 32'(u_if.pc), 32'h0);
        tick(); tick();
        check("arst_next_pc", 32'(u_if.pc), 32'h1);
        tick();
        check("bwrite_instr_path", 32'(u_if.instructions), 32'h5678);

        // Revisit address 3: the earlier write must now be visible
        u_if.en_cnt    = 1'b0;
        u_if.en_offset = 1'b1;
        u_if.pc_offset = 4'd2;
        tick(); tick();
        check("to3_pc", 32'(u_if.pc), 32'h3);
        u_if.en_offset = 1'b0;
        tick();
        check("wr_new_word", 32'(u_if.instructions), 32'hBEEF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
